aes_128_in_sched: RTL

- Input scheduler directly upstream of the AES-128 core.
- Buffers 128-bit plaintext blocks from a valid/ready source in a small FIFO.
- Issues one block at a time to the core's in_data/in_en pair, and only when the core reports idle.
- Waits for each block to complete before issuing the next, so the core never sees an in_en collision.

---
 rtl/aes_128_pkg.sv | 14 +
 rtl/aes_128_in_sched_if.sv | 9 +
 rtl/aes_128_block_fifo.sv | 57 +++++
 rtl/aes_128_in_sched.sv | 110 +++++++++++
 4 files changed

// File: rtl/aes_128_pkg.sv
// Shared types for the AES-128 input scheduler: block type and scheduler FSM states.
package aes_128_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } sched_state_t;

endpackage

// File: rtl/aes_128_in_sched_if.sv
// Valid/ready plaintext stream feeding the AES-128 input scheduler.
interface aes_128_in_sched_if;
  aes_128_pkg::aes_block_t s_data;
  logic                    s_valid;
  logic                    s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/aes_128_block_fifo.sv
// Block FIFO with synchronous kill; the registered read port is the issue register
// that drives the core, so it holds the last popped block between pops.
module aes_128_block_fifo
  import aes_128_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     kill,
  input  logic                     push_i,
  input  aes_block_t               wr_data_i,
  input  logic                     pop_i,
  output aes_block_t               rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  aes_block_t        mem_q [DEPTH];
  aes_block_t        rd_data_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset: contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push && !kill) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;

endmodule

// File: rtl/aes_128_in_sched.sv
// AES-128 input scheduler: queues plaintext and issues one block at a time to an idle core.
// Optional issue/loss statistics counters under AES_IN_SCHED_STATS_EN.
module aes_128_in_sched
  import aes_128_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   kill,
  aes_128_in_sched_if.slave      s,
  input  logic                   core_idle,
  output aes_block_t             core_in_data,
  output logic                   core_in_en,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   lost_irq_pulse
`ifdef AES_IN_SCHED_STATS_EN
  ,
  output logic [31:0]            issued_cnt,
  output logic [15:0]            lost_cnt
`endif
);

  localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

  sched_state_t state_q;
  logic [7:0]   tmo_q;
  logic         en_q, lost_q;
  logic         issue, tmo_hit;

  assign issue   = (state_q == S_IDLE) && !empty && core_idle;
  assign tmo_hit = (state_q == S_WAIT_BUSY) && core_idle && (tmo_q == TMO_LAST);

  aes_128_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .kill      (kill),
    .push_i    (s.s_valid),
    .wr_data_i (s.s_data),
    .pop_i     (issue),
    .rd_data_o (core_in_data),
    .level_o   (level),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign s.s_ready = !full;

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      en_q    <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      lost_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (issue) begin
            en_q    <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          // The core must acknowledge by dropping idle; otherwise the block is abandoned.
          if (!core_idle) begin
            tmo_q   <= '0;
            state_q <= S_WAIT_DONE;
          end else if (tmo_hit) begin
            lost_q  <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (core_idle) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_in_en     = en_q;
  assign lost_irq_pulse = lost_q;

`ifdef AES_IN_SCHED_STATS_EN
  logic [31:0] issued_q;
  logic [15:0] lostc_q;

  // Counted on the decision edge so the counters move with the strobe itself.
  always_ff @(posedge clk) begin
    if (kill) begin
      issued_q <= '0;
      lostc_q  <= '0;
    end else begin
      if (issue && (issued_q != '1)) issued_q <= issued_q + 32'd1;
      if (tmo_hit && (lostc_q != '1)) lostc_q <= lostc_q + 16'd1;
    end
  end

  assign issued_cnt = issued_q;
  assign lost_cnt   = lostc_q;
`endif

endmodule
